// File: rtl/mat_mult_tiled_engine_if.sv
//============================================================================
// Module      : mat_mult_tiled_engine_if
// Description : Command/operand/result bundle for the tiled matrix engine.
//               master : requester (drives start, modes, operand matrices)
//               slave  : engine    (drives C_flat, busy, done)
//               Ports  : start, acc_mode, signed_mode, A_flat, B_flat  (req)
//                        C_flat, busy, done                            (rsp)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface mat_mult_tiled_engine_if #(
    parameter int WIDTH = 16,
    parameter int N     = 16,
    parameter int ACC_W = 2*WIDTH + $clog2(N)
);
    logic                     start;
    logic                     acc_mode;
    logic                     signed_mode;
    logic [WIDTH*N*N-1:0]     A_flat;
    logic [WIDTH*N*N-1:0]     B_flat;
    logic [ACC_W*N*N-1:0]     C_flat;
    logic                     busy;
    logic                     done;

    modport master (
        output start, acc_mode, signed_mode, A_flat, B_flat,
        input  C_flat, busy, done
    );

    modport slave (
        input  start, acc_mode, signed_mode, A_flat, B_flat,
        output C_flat, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/mat_mult_tiled_engine.sv
//============================================================================
// Module      : mat_mult_tiled_engine
// Description : Tiled N x N matrix multiplier, C = A*B or C = C + A*B.
//               (N/T)^2 tile multipliers of T x T each step through N/T
//               inner-dimension passes (LOAD then ACC per pass).
//               Ports  : clk   - rising-edge clock
//                        rst_n - asynchronous active-low reset
//                        bus   - mat_mult_tiled_engine_if.slave
//                                (start/acc_mode/signed_mode/A_flat/B_flat
//                                 in; C_flat/busy/done out, all registered)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mat_mult_tiled_engine #(
    parameter int WIDTH = 16,
    parameter int N     = 16,
    parameter int T     = 2,
    parameter int ACC_W = 2*WIDTH + $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mat_mult_tiled_engine_if.slave bus
);

    localparam int NT     = N / T;
    localparam int PASS_W = (NT > 1) ? $clog2(NT) : 1;
    localparam int OP_W   = WIDTH * N * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [PASS_W-1:0]      pass;
    logic [OP_W-1:0]        a_lat;
    logic [OP_W-1:0]        b_lat;
    logic                   signed_lat;
    logic                   busy_r;
    logic                   done_r;

    // Per-tile operand registers: tile (i,j) holds its own A and B sub-blocks.
    logic [WIDTH-1:0]       tile_a [NT][NT][T][T];
    logic [WIDTH-1:0]       tile_b [NT][NT][T][T];

    logic [ACC_W-1:0]       c_reg    [N][N];
    logic [ACC_W-1:0]       tile_sum [N][N];

    // Exact product of two WIDTH-bit operands, extended to ACC_W bits.
    // Operands gain one extension bit so a single signed multiplier covers
    // both modes; the true product always fits, so the size cast either
    // sign-extends (negative signed results) or reproduces it modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] mul_ext(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn
    );
        logic signed [WIDTH:0]     ea;
        logic signed [WIDTH:0]     eb;
        logic signed [2*WIDTH+1:0] p;
        ea = {sgn & a[WIDTH-1], a};
        eb = {sgn & b[WIDTH-1], b};
        p  = ea * eb;
        return ACC_W'(p);
    endfunction

    // Tile multipliers: combinational T-term dot product per C element,
    // taken from the operands registered in the previous LOAD.
    for (genvar gi = 0; gi < NT; gi++) begin : g_tile_row
        for (genvar gj = 0; gj < NT; gj++) begin : g_tile_col
            for (genvar gr = 0; gr < T; gr++) begin : g_elem_row
                for (genvar gc = 0; gc < T; gc++) begin : g_elem_col
                    logic [ACC_W-1:0] dot;
                    always_comb begin
                        dot = '0;
                        for (int k = 0; k < T; k++) begin
                            dot = dot + mul_ext(tile_a[gi][gj][gr][k],
                                                tile_b[gi][gj][k][gc],
                                                signed_lat);
                        end
                    end
                    assign tile_sum[gi*T+gr][gj*T+gc] = dot;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pass       <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            a_lat      <= '0;
            b_lat      <= '0;
            signed_lat <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    c_reg[r][c] <= '0;
                end
            end
            for (int i = 0; i < NT; i++) begin
                for (int j = 0; j < NT; j++) begin
                    for (int r = 0; r < T; r++) begin
                        for (int c = 0; c < T; c++) begin
                            tile_a[i][j][r][c] <= '0;
                            tile_b[i][j][r][c] <= '0;
                        end
                    end
                end
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_lat      <= bus.A_flat;
                        b_lat      <= bus.B_flat;
                        signed_lat <= bus.signed_mode;
                        pass       <= '0;
                        state      <= LOAD;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        // acc_mode only matters here: it decides whether
                        // the previous result is the starting accumulator.
                        if (!bus.acc_mode) begin
                            for (int r = 0; r < N; r++) begin
                                for (int c = 0; c < N; c++) begin
                                    c_reg[r][c] <= '0;
                                end
                            end
                        end
                    end
                end
                LOAD: begin
                    for (int i = 0; i < NT; i++) begin
                        for (int j = 0; j < NT; j++) begin
                            for (int r = 0; r < T; r++) begin
                                for (int c = 0; c < T; c++) begin
                                    tile_a[i][j][r][c] <= a_lat[((i*T + r)*N + int'(pass)*T + c)*WIDTH +: WIDTH];
                                    tile_b[i][j][r][c] <= b_lat[((int'(pass)*T + r)*N + j*T + c)*WIDTH +: WIDTH];
                                end
                            end
                        end
                    end
                    state <= ACC;
                end
                ACC: begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            c_reg[r][c] <= c_reg[r][c] + tile_sum[r][c];
                        end
                    end
                    if (pass == PASS_W'(NT - 1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        pass  <= pass + 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar gr = 0; gr < N; gr++) begin : g_out_row
        for (genvar gc = 0; gc < N; gc++) begin : g_out_col
            assign bus.C_flat[(gr*N + gc)*ACC_W +: ACC_W] = c_reg[gr][gc];
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

`default_nettype wire

// File: doc/mat_mult_tiled_engine.md
# mat_mult_tiled_engine

Parametrised tiled matrix multiplier that computes C = A×B, or C = C + A×B, for two N×N matrices held in flattened operand buses. An array of (N/T)² T×T tile multipliers steps through the N/T inner-dimension passes under a start/busy/done handshake. Operands are captured when start is accepted, and signed and unsigned arithmetic are both supported. It replaces the fixed 16×16, 2×2-tile multiplier in the accelerator datapath.

## Interface
- WIDTH, 16: operand element width in bits.
- N, 16: matrix dimension. Must be a multiple of T and at least T.
- T, 2: tile dimension. The block instantiates (N/T)² tile multipliers of T×T.
- ACC_W, 2*WIDTH+$clog2(N): width of each result element. Must be at least 2*WIDTH+$clog2(N).

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new multiply; sampled only in IDLE or DONE.
- acc_mode  in  1  sampled with start. 0: C = A×B. 1: C = C_prev + A×B.
- signed_mode  in  1  sampled with start. 1: operands are two's complement.
- A_flat  in  WIDTH*N*N  element (r,k) at bits [(r*N+k)*WIDTH +: WIDTH].
- B_flat  in  WIDTH*N*N  element (k,c) at bits [(k*N+c)*WIDTH +: WIDTH].
- C_flat  out  ACC_W*N*N  element (r,c) at bits [(r*N+c)*ACC_W +: ACC_W].
- busy  out  1  high from start acceptance until done rises.
- done  out  1  level; high in DONE, cleared on the next accepted start.

## Operation
- States and transitions:
  - IDLE → LOAD on start.
  - LOAD → ACC unconditionally.
  - ACC → LOAD while pass < N/T−1, with pass incremented.
  - ACC → DONE on the last pass.
  - DONE → LOAD on start.
- Start acceptance (IDLE or DONE with start=1):
  - A_flat, B_flat, acc_mode and signed_mode are latched into internal registers. Inputs may change afterwards without effect.
  - pass is set to 0.
  - If acc_mode=0, C_flat is cleared to 0 at the same edge. If acc_mode=1, C_flat is kept.
- LOAD, pass p:
  - Tile (i,j) registers A sub-block rows [iT, iT+T), columns [pT, pT+T).
  - It also registers B sub-block rows [pT, pT+T), columns [jT, jT+T).
- ACC, pass p: every C element (r,c) adds the combinational tile product Σ_{k=pT}^{pT+T−1} A[r][k]·B[k][c].
- Arithmetic:
  - Products are 2*WIDTH bits, sign- or zero-extended to ACC_W per the latched signed_mode.
  - Accumulation is modulo 2^ACC_W. There is no saturation.
  - acc_mode=1 can therefore wrap; this is defined behaviour.
- start during LOAD/ACC is ignored: no restart, no latch update.
- C_flat is stable and valid whenever done=1. Its value during busy is undefined to consumers.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, pass=0, C_flat=0, busy=0, done=0. Takes effect immediately.
- Reset mid-operation: the current computation is abandoned. The block accepts a new start on the first edge after rst_n rises.
- Latency from start acceptance:
  - Start accepted at edge e0.
  - LOAD of pass p at edge e(2p+1); ACC of pass p at edge e(2p+2).
  - done rises and busy falls at edge e(2·N/T), i.e. 2·N/T cycles after acceptance. This is 16 for N=16, T=2.
- busy rises at e0, and done falls at e0.
- Back-to-back: start held high in DONE is accepted at the very next edge. Throughput is one multiply per 2·N/T+1 cycles.
- No output is combinational from inputs; all outputs are registered.

## Test plan
- N=4, T=2, unsigned, acc_mode=0, A=identity, B[k][c]=4k+c → C[r][c]=4r+c. done high exactly 4 cycles after start accepted; busy high for those 4 cycles.
- N=16, T=2, unsigned, all A=B=0xFFFF → every C element = 16·0xFFFF² = 0xFFFE_0001_0 (0xFFFE00010). done after 16 cycles.
- Signed, N=4: A all −1 (0xFFFF), B all 3 → every C element = −12 (ACC_W-bit two's complement). The same stimulus with signed_mode=0 → 4·65535·3 = 786420.
- Accumulate: run A=I, B=all 2 with acc_mode=0, then the same with acc_mode=1 → all C=4. Then acc_mode=0 → all C=2.
- Pulse start in pass 1 with different A/B → ignored; result and done timing unchanged. Change A_flat after acceptance → result unchanged.
- Assert rst_n=0 during pass 2 → C_flat=0, busy=0 and done=0 immediately. A new start after release yields a correct result in 2·N/T cycles.
